// File: rtl/present_pkg.sv
// present_pkg
// Shared definitions for the iterative PRESENT-80 engine.
//   state_e      : controller phases (IDLE, ADD, SUB, PERM, FINAL, DONE)
//   ROUNDS       : number of full cipher rounds before the final whitening
//   KEY_W, BLK_W : key register and data block widths
//   legal_nsbox  : true when the S-box count divides the 16 nibbles evenly
package present_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SUB,
        PERM,
        FINAL,
        DONE
    } state_e;

    localparam int ROUNDS = 31;
    localparam int KEY_W  = 80;
    localparam int BLK_W  = 64;

    // Only powers of two up to 16 let the nibble pointer wrap cleanly.
    function automatic bit legal_nsbox(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

endpackage

// File: rtl/SBox.sv
// SBox
// The 4-bit PRESENT substitution box, purely combinational.
//   x : input nibble
//   y : substituted nibble
module SBox (
    input  logic [3:0] x,
    output logic [3:0] y
);

    // Lookup table: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2
    always_comb begin
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            default: y = 4'h2;
        endcase
    end

endmodule

// File: rtl/present_player.sv
// present_player
// PRESENT bit permutation layer (pLayer), purely combinational.
//   x : 64-bit state before permutation
//   y : 64-bit state after permutation; bit i of x lands at (16*i) mod 63,
//       bit 63 stays in place
module present_player
    import present_pkg::*;
(
    input  logic [BLK_W-1:0] x,
    output logic [BLK_W-1:0] y
);

    for (genvar i = 0; i < BLK_W - 1; i++) begin : g_bit
        assign y[(16 * i) % 63] = x[i];
    end

    assign y[BLK_W-1] = x[BLK_W-1];

endmodule

// File: rtl/present_round_ctrl.sv
// present_round_ctrl
// Iterative PRESENT-80 encryption engine. The 16-nibble substitution layer
// is spread over 16/NSBOX cycles using NSBOX shared S-box instances.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   start : request, only honoured in IDLE
//   din   : 64-bit plaintext, captured on an accepted start
//   key   : 80-bit key, captured on an accepted start
//   busy  : high from the cycle after start through the FINAL cycle
//   done  : one-cycle pulse when dout carries a fresh ciphertext
//   dout  : ciphertext, held until the next operation's FINAL cycle
module present_round_ctrl
    import present_pkg::*;
#(
    parameter int NSBOX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BLK_W-1:0] din,
    input  logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             done,
    output logic [BLK_W-1:0] dout
);

    if (!legal_nsbox(NSBOX)) begin : g_bad_nsbox
        $error("present_round_ctrl: NSBOX must be 1, 2, 4, 8 or 16");
    end

    // With NSBOX=16 the step truncates to 0, which keeps np parked at 0.
    localparam logic [3:0] NP_STEP = 4'(NSBOX);
    localparam logic [3:0] NP_LAST = 4'(16 - NSBOX);

    state_e           fsm;
    logic [BLK_W-1:0] state_reg;
    logic [KEY_W-1:0] key_reg;
    logic [4:0]       rc;
    logic [3:0]       np;

    logic [BLK_W-1:0] round_key;
    logic [BLK_W-1:0] sub_next;
    logic [BLK_W-1:0] perm_next;
    logic [KEY_W-1:0] key_rot;
    logic [KEY_W-1:0] key_next;
    logic [3:0]       ks_out;

    logic [3:0] nib_idx  [NSBOX];
    logic [3:0] sbox_in  [NSBOX];
    logic [3:0] sbox_out [NSBOX];

    assign round_key = key_reg[KEY_W-1:KEY_W-BLK_W];

    // Each shared S-box j works on nibble np+j of the current state.
    for (genvar j = 0; j < NSBOX; j++) begin : g_sbox
        assign nib_idx[j] = np + 4'(j);
        assign sbox_in[j] = state_reg[{nib_idx[j], 2'b00} +: 4];
        SBox u_sbox (
            .x (sbox_in[j]),
            .y (sbox_out[j])
        );
    end

    // State with this cycle's window of nibbles substituted.
    always_comb begin
        sub_next = state_reg;
        for (int j = 0; j < NSBOX; j++) begin
            sub_next[{nib_idx[j], 2'b00} +: 4] = sbox_out[j];
        end
    end

    present_player u_player (
        .x (state_reg),
        .y (perm_next)
    );

    // Key schedule: rotate left by 61 (equivalently right by 19), S-box
    // the top nibble and fold the round counter into bits [19:15].
    assign key_rot = {key_reg[18:0], key_reg[KEY_W-1:19]};

    SBox u_ks_sbox (
        .x (key_rot[79:76]),
        .y (ks_out)
    );

    always_comb begin
        key_next        = key_rot;
        key_next[79:76] = ks_out;
        key_next[19:15] = key_rot[19:15] ^ rc;
    end

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rc        <= '0;
            np        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dout      <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start) begin
                        state_reg <= din;
                        key_reg   <= key;
                        rc        <= 5'd1;
                        np        <= '0;
                        busy      <= 1'b1;
                        fsm       <= ADD;
                    end
                end
                ADD: begin
                    state_reg <= state_reg ^ round_key;
                    fsm       <= SUB;
                end
                SUB: begin
                    state_reg <= sub_next;
                    if (np == NP_LAST) begin
                        np  <= '0;
                        fsm <= PERM;
                    end else begin
                        np  <= np + NP_STEP;
                    end
                end
                PERM: begin
                    state_reg <= perm_next;
                    key_reg   <= key_next;
                    if (rc == 5'(ROUNDS)) begin
                        fsm <= FINAL;
                    end else begin
                        rc  <= rc + 5'd1;
                        fsm <= ADD;
                    end
                end
                FINAL: begin
                    dout <= state_reg ^ round_key;
                    busy <= 1'b0;
                    done <= 1'b1;
                    fsm  <= DONE;
                end
                DONE: begin
                    done <= 1'b0;
                    fsm  <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_round_ctrl.sv
// tb_present_round_ctrl
// Scoreboarded bench for the PRESENT-80 engine: an NSBOX=4 instance takes the
// directed scenarios, four more instances (NSBOX 1, 2, 8, 16) share one start
// line for the known-answer vectors. Each issued operation queues its expected
// ciphertext and done cycle; a monitor pops and compares on every done pulse.
module tb_present_round_ctrl;

    localparam logic [63:0] P_ZERO = 64'h0;
    localparam logic [63:0] P_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] K_ZERO = 80'h0;
    localparam logic [79:0] K_ONES = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    localparam logic [63:0] CT_00 = 64'h5579C1387B228445;
    localparam logic [63:0] CT_10 = 64'hA112FFC72F68417B;
    localparam logic [63:0] CT_01 = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT_11 = 64'h3333DCD3213210D2;

    localparam int unsigned MAIN_LAT = 188;
    localparam int unsigned ALT_LAT [4] = '{560, 312, 126, 95};

    typedef struct {
        int          id;
        logic [63:0] ct;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        alt_start;
    logic [63:0] din;
    logic [79:0] key;
    logic        busy;
    logic        done;
    logic [63:0] dout;
    logic        alt_busy [4];
    logic        alt_done [4];
    logic [63:0] alt_dout [4];

    int unsigned cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    exp_t        exp_q[$];

    // Free-running clock and cycle counter used to timestamp expectations.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    present_round_ctrl #(.NSBOX(4)) u_main (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (din),
        .key   (key),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    for (genvar g = 0; g < 4; g++) begin : g_alt
        present_round_ctrl #(
            .NSBOX((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16)
        ) u_alt (
            .clk   (clk),
            .reset (reset),
            .start (alt_start),
            .din   (din),
            .key   (key),
            .busy  (alt_busy[g]),
            .done  (alt_done[g]),
            .dout  (alt_dout[g])
        );
    end

    task automatic checkOutput(input string name, input logic [79:0] actual,
                               input logic [79:0] expected);
        nvec++;
        if (actual !== expected) begin
            nerr++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: match every done pulse against the oldest pending entry of
    // that instance, and watch the main instance's busy/done waveform.
    logic prev_done = 1'b0;
    int   busy_len = 0;

    always @(negedge clk) begin
        logic        d;
        logic [63:0] o;
        int          idx;
        exp_t        e;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                d = done;
                o = dout;
            end else begin
                d = alt_done[k-1];
                o = alt_dout[k-1];
            end
            if (d) begin
                idx = -1;
                foreach (exp_q[i]) begin
                    if (idx < 0 && exp_q[i].id == k) idx = i;
                end
                if (idx < 0) begin
                    nvec++;
                    nerr++;
                    $display("[TB] FAIL unexpected_done: dut %0d pulsed done at cycle %0d with dout %h, expected no result",
                             k, cyc, o);
                end else begin
                    e = exp_q[idx];
                    exp_q.delete(idx);
                    checkOutput($sformatf("dout_dut%0d", k), 80'(o), 80'(e.ct));
                    checkOutput($sformatf("done_cycle_dut%0d", k), 80'(cyc), 80'(e.cyc));
                end
            end
        end
        if (prev_done) checkOutput("done_single_cycle", 80'(done), 80'd0);
        if (done) checkOutput("busy_low_at_done", 80'(busy), 80'd0);
        if (busy) begin
            busy_len++;
        end else begin
            if (done) checkOutput("busy_cycles", 80'(busy_len), 80'(MAIN_LAT - 1));
            busy_len = 0;
        end
        prev_done = done;
    end

    task automatic scrambleInputs();
        din = {$urandom, $urandom};
        key = {16'($urandom), $urandom, $urandom};
    endtask

    task automatic applyStimulus(input logic [63:0] p, input logic [79:0] k,
                                 input logic [63:0] ct);
        @(negedge clk);
        start = 1'b1;
        din   = p;
        key   = k;
        exp_q.push_back('{0, ct, cyc + MAIN_LAT});
        @(negedge clk);
        start = 1'b0;
        scrambleInputs();
    endtask

    task automatic applyAltStimulus(input logic [63:0] p, input logic [79:0] k,
                                    input logic [63:0] ct);
        @(negedge clk);
        alt_start = 1'b1;
        din       = p;
        key       = k;
        for (int g = 0; g < 4; g++) exp_q.push_back('{g + 1, ct, cyc + ALT_LAT[g]});
        @(negedge clk);
        alt_start = 1'b0;
        scrambleInputs();
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            nvec++;
            nerr++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding after %0d cycles, expected 0",
                     exp_q.size(), limit);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // start held high for a whole operation with inputs wandering: only the
    // first-cycle inputs count, and the next accept happens in IDLE after DONE.
    task automatic startHeld();
        int unsigned c;
        @(negedge clk);
        c     = cyc;
        start = 1'b1;
        din   = P_ZERO;
        key   = K_ZERO;
        exp_q.push_back('{0, CT_00, c + MAIN_LAT});
        repeat (5) @(negedge clk);
        scrambleInputs();
        repeat (180) @(negedge clk);
        din = P_ONES;
        key = K_ZERO;
        exp_q.push_back('{0, CT_10, c + MAIN_LAT + 1 + MAIN_LAT});
        repeat (5) @(negedge clk);
        start = 1'b0;
        scrambleInputs();
        waitDrain(800);
    endtask

    // Reset in SUB of round 10 (cycle 56), then a clean run at normal latency.
    task automatic resetMidRun();
        @(negedge clk);
        start = 1'b1;
        din   = P_ONES;
        key   = K_ONES;
        exp_q.push_back('{0, CT_11, cyc + MAIN_LAT});
        @(negedge clk);
        start = 1'b0;
        scrambleInputs();
        repeat (55) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("busy_after_reset", 80'(busy), 80'd0);
        checkOutput("done_after_reset", 80'(done), 80'd0);
        checkOutput("dout_after_reset", 80'(dout), 80'd0);
        exp_q.delete();
        reset = 1'b0;
        applyStimulus(P_ZERO, K_ZERO, CT_00);
        waitDrain(400);
    endtask

    // Hang guard: report and stop if the sequence never completes.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence.
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        alt_start = 1'b0;
        din       = '0;
        key       = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 80'(busy), 80'd0);
        checkOutput("reset_done", 80'(done), 80'd0);
        checkOutput("reset_dout", 80'(dout), 80'd0);
        reset = 1'b0;

        applyStimulus(P_ZERO, K_ZERO, CT_00);
        waitDrain(400);
        checkOutput("dout_hold_idle", 80'(dout), 80'(CT_00));

        applyStimulus(P_ONES, K_ZERO, CT_10);
        repeat (100) @(negedge clk);
        checkOutput("dout_hold_busy", 80'(dout), 80'(CT_00));
        waitDrain(400);

        applyStimulus(P_ZERO, K_ONES, CT_01);
        waitDrain(400);
        applyStimulus(P_ONES, K_ONES, CT_11);
        waitDrain(400);

        startHeld();
        resetMidRun();

        applyAltStimulus(P_ZERO, K_ZERO, CT_00);
        waitDrain(700);
        applyAltStimulus(P_ONES, K_ZERO, CT_10);
        waitDrain(700);
        applyAltStimulus(P_ZERO, K_ONES, CT_01);
        waitDrain(700);
        applyAltStimulus(P_ONES, K_ONES, CT_11);
        waitDrain(700);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
